// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the shared-ALU arbiter slice: datapath width,
//   ALU opcode encodings and the response FSM state type.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/alu32_core.sv
// alu32_core
//   Purely combinational ALU: AND/OR/XOR/ADD/SUB/SLT.
//   Ports: op (3) opcode; a, b (WIDTH) operands;
//          result (WIDTH) ALU output (0 for illegal opcodes);
//          zero  result == 0; err  opcode is illegal (110/111).
module alu32_core
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         err
);

  logic [W-1:0] and_y;
  logic [W-1:0] or_y;
  logic [W-1:0] xor_y;
  logic [W-1:0] b_sel;
  logic [W-1:0] addsub;
  logic         do_sub;
  logic         lt;

  and32 #(.W(W)) u_and (.a(a), .b(b), .y(and_y));
  or32  #(.W(W)) u_or  (.a(a), .b(b), .y(or_y));
  xor32 #(.W(W)) u_xor (.a(a), .b(b), .y(xor_y));

  // One shared adder: SUB and SLT both compute a + ~b + 1.
  assign do_sub = (op == OP_SUB) || (op == OP_SLT);
  assign b_sel  = do_sub ? ~b : b;
  assign addsub = a + b_sel + {{(W-1){1'b0}}, do_sub};

  // Signed less-than: differing signs decide directly (avoids overflow),
  // otherwise the sign of the difference does.
  assign lt = (a[W-1] ^ b[W-1]) ? a[W-1] : addsub[W-1];

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:  result = and_y;
      OP_OR:   result = or_y;
      OP_XOR:  result = xor_y;
      OP_ADD:  result = addsub;
      OP_SUB:  result = addsub;
      OP_SLT:  result = {{(W-1){1'b0}}, lt};
      default: err    = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/and32.sv
// and32
//   Bitwise AND gate array.
//   Ports: a, b (W) operands; y (W) a & b.
module and32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a & b;
endmodule

// File: rtl/or32.sv
// or32
//   Bitwise OR gate array.
//   Ports: a, b (W) operands; y (W) a | b.
module or32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a | b;
endmodule

// File: rtl/xor32.sv
// xor32
//   Bitwise XOR gate array.
//   Ports: a, b (W) operands; y (W) a ^ b.
module xor32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one alu32_core between two valid/ready requesters with
//   round-robin arbitration and a single registered response stage.
//   Ports: clk, rst_n (async active-low);
//          reqN_valid/reqN_ready/reqN_op/reqN_a/reqN_b  requester N (N=0,1);
//          rsp_valid/rsp_ready  response handshake;
//          rsp_id  owner of the result; rsp_result/rsp_zero/rsp_err  ALU outputs.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_err
);

  state_t       state;
  state_t       state_next;
  logic         prio;
  logic         can_accept;
  logic         grant0;
  logic         grant1;
  logic         grant;
  logic [2:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         alu_err;

  // rst_n is folded in so no ready can be seen while reset is held.
  assign can_accept = rst_n &&
                      ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));

  // A lone requester always wins; under contention prio picks the winner.
  assign grant0 = can_accept && req0_valid && (!req1_valid || (prio == 1'b0));
  assign grant1 = can_accept && req1_valid && (!req0_valid || (prio == 1'b1));
  assign grant  = grant0 || grant1;

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  alu32_core #(.W(W)) u_core (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A grant always (re)fills the response stage; otherwise RESP drains on rsp_ready.
  always_comb begin
    state_next = state;
    if (grant)
      state_next = ST_RESP;
    else if ((state == ST_RESP) && rsp_ready)
      state_next = ST_IDLE;
  end

  always_comb begin
    rsp_valid  = (state == ST_RESP);
    req0_ready = grant0;
    req1_ready = grant1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (grant) begin
      rsp_id     <= grant1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_err    <= alu_err;
    end
  end

  // The pointer favours the loser of the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio <= 1'b0;
    else if (grant)  prio <= ~grant1;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 32-bit combinational ALU core (AND/OR/XOR/ADD/SUB/SLT) between two requesters, e.g. the integer pipeline and the address/branch unit. Each requester uses a valid/ready handshake. The block grants the ALU round-robin, registers the selected operands' result, and returns it with the winner's ID on a single response port under valid/ready flow control. It sits between issue logic and writeback and is the only owner of the ALU datapath.

## Interface
- WIDTH, 32, operand/result width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  3  opcode
- req0_a, req0_b  input  WIDTH  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0
- rsp_valid  output  1  result held
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that owns the result
- rsp_result  output  WIDTH  ALU result
- rsp_zero  output  1  rsp_result == 0
- rsp_err  output  1  opcode was illegal

## Operation
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 ADD (mod 2^WIDTH, carry dropped).
  - 100 SUB (a−b mod 2^WIDTH), 101 SLT (signed a<b → 1, else 0).
  - 110/111 illegal: result 0, rsp_err=1, rsp_zero=1.
- FSM states:
  - IDLE: rsp_valid=0.
  - RESP: rsp_valid=1; outputs frozen until handshake.
- Accept condition: `can_accept = (state==IDLE) | (state==RESP & rsp_ready)`.
- Arbitration:
  - When can_accept and exactly one reqN_valid: grant N.
  - Both valid: grant the requester indicated by the priority pointer `prio`. After a grant to k, `prio ← ~k`.
  - `prio` changes only on a grant.
- Grant effects:
  - reqN_ready=1 for the winner only, combinationally, in the same cycle.
  - A loser keeps valid and its payload stable; requesters may not drop valid before ready.
  - At the clock edge: rsp_result/zero/err ← ALU output of the winner; rsp_id ← N; state ← RESP.
- RESP with rsp_ready=1 and no grant: state ← IDLE.
- RESP with rsp_ready=0: no readies asserted, result held.
- reqN_ready never asserts without the matching reqN_valid.

## Timing
- Reset (async assert, sync release): state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, prio=0 (req0 preferred), req0_ready=req1_ready=0.
- Latency: accept at edge T → rsp_valid high from T+1.
- Throughput: one op per cycle when rsp_ready is held high. The accept and the response handshake in the same cycle are legal and lossless.
- Back-pressure: rsp_ready low in RESP stalls both requesters indefinitely; no response is overwritten.
- Simultaneous valid arrival with the pointer at either value: strict alternation under sustained contention, starvation bound of 1 grant.
- Reset mid-operation: any held response is discarded; a requester whose ready was not yet seen must re-present.

## Structure
- Package alu_pkg:
  - opcode localparams: OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLT.
  - FSM state encoding: ST_IDLE, ST_RESP.
  - WIDTH default.
- Sub-module alu32_core, purely combinational: inputs op, a, b; outputs result, zero, err. It reuses the existing 32-bit bitwise gates (and32/or32/xor32) plus an adder/subtractor.
- The arbiter is one module with a single registered response stage and the priority flop.

## Test plan
- **Reset:** assert rst_n=0 mid-RESP → all outputs 0 immediately; after release, req0/req1 both valid → req0 granted first.
- **XOR:** req0 only, op=XOR, A=0xAAAAAAAA, B=0xDDDDDDDD, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=0x77777777, zero=0.
- **ADD/SUB/SLT via requester 1:**
  - ADD 0xFFFFFFFF+0x00000001 → result 0x00000000, zero=1.
  - SUB 0−1 → 0xFFFFFFFF.
  - SLT A=0xFFFFFFFF, B=0x00000001 → 0x00000001.
- **Contention:** both valid for 4 cycles, rsp_ready=1 → grants 0,1,0,1; rsp_id sequence 0,1,0,1; each result matches its own operands (XOR 0x000000AA^0x000000AB=0x00000001).
- **Back-pressure:** rsp_ready=0 for 5 cycles with both valid → rsp fields stable, no ready asserted. Release → the pending result is taken and the next grant occurs in the same cycle.
- **Illegal opcode:** op=111 → rsp_err=1, rsp_result=0, rsp_zero=1. The following legal op has err=0.
